// File: rtl/jtag_vector_player.sv
// jtag_vector_player
// Plays a preloaded memory of TMS/TDI vectors out as a divided TCK waveform
// and collects the returned TDO history. LANES parallel TDI lanes share one
// TMS. Each vector is one FETCH cycle, clk_div+1 cycles of TCK low and
// clk_div+1 cycles of TCK high, so one vector lasts 2*clk_div+3 clk cycles.
//
// Optional build macro: JTAG_VECTOR_PLAYER_LOOP_EN
//   Adds input loop_i, latched with start. When latched high, playback wraps
//   from the last vector back to vector 0 and only abort or reset ends it.
//   With the macro undefined there is no loop_i port and playback always
//   stops after the last vector.

module jtag_vector_player #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13,
  parameter int LANES  = 1,
  parameter int DIV_W  = 8,
  parameter int CAP_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_tms,
  input  logic [LANES-1:0]  wr_tdi,
  input  logic              start,
`ifdef JTAG_VECTOR_PLAYER_LOOP_EN
  input  logic              loop_i,
`endif
  input  logic [ADDR_W:0]   length,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              abort,
  input  logic              tdo_i,
  output logic              tck_o,
  output logic              tms_o,
  output logic [LANES-1:0]  tdi_o,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] vec_idx,
  output logic [CAP_W-1:0]  tdo_word
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  // Vector storage: bit 0 is TMS, bits LANES:1 are the TDI lanes.
  logic [LANES:0]    mem_q [DEPTH];
  logic [LANES:0]    memRd;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] lastAddr_q;
  logic [DIV_W-1:0]  clkDiv_q;
  logic [DIV_W-1:0]  divCnt_q;
  logic              loop_q;

  logic              tck_q;
  logic              tms_q;
  logic [LANES-1:0]  tdi_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic [ADDR_W-1:0] vecIdx_q;
  logic [CAP_W-1:0]  tdoWord_q;

  logic [ADDR_W:0]   lenClamped_d;
  logic [ADDR_W-1:0] lastAddr_d;
  logic              loopSel;
  logic              isLastVec;
  logic              phaseEnd;

`ifdef JTAG_VECTOR_PLAYER_LOOP_EN
  assign loopSel = loop_i;
`else
  assign loopSel = 1'b0;
`endif

  // Lengths beyond the memory size are limited to DEPTH; the last address is
  // precomputed so the end-of-run test is a plain equality compare.
  always_comb begin
    lenClamped_d = (length > DEPTH_L) ? DEPTH_L : length;
    lastAddr_d   = ADDR_W'(lenClamped_d - (ADDR_W+1)'(1));
  end

  assign isLastVec = (addr_q == lastAddr_q);
  assign phaseEnd  = (divCnt_q == clkDiv_q);
  assign memRd     = mem_q[addr_q];

  // Vector memory write port; writes are locked out while a run is active
  // so the playing pattern can never change underneath itself.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= {wr_tdi, wr_tms};
    end
  end

  // Playback sequencer with all pin-facing outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      lastAddr_q <= '0;
      clkDiv_q   <= '0;
      divCnt_q   <= '0;
      loop_q     <= 1'b0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      vecIdx_q   <= '0;
      tdoWord_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          tck_q <= 1'b0;
          if (start) begin
            clkDiv_q   <= clk_div;
            lastAddr_q <= lastAddr_d;
            loop_q     <= loopSel;
            addr_q     <= '0;
            divCnt_q   <= '0;
            if (length == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (abort) begin
            tck_q     <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            tms_q    <= memRd[0];
            tdi_q    <= memRd[LANES:1];
            vecIdx_q <= addr_q;
            divCnt_q <= '0;
            state_q  <= S_LOW;
          end
        end

        S_LOW: begin
          if (abort) begin
            tck_q     <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (phaseEnd) begin
            divCnt_q <= '0;
            tck_q    <= 1'b1;
            state_q  <= S_HIGH;
          end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
          end
        end

        S_HIGH: begin
          if (abort) begin
            tck_q     <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            if (divCnt_q == '0) begin
              tdoWord_q <= {tdo_i, tdoWord_q[CAP_W-1:1]};
            end
            if (phaseEnd) begin
              tck_q    <= 1'b0;
              divCnt_q <= '0;
              if (isLastVec && !loop_q) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                addr_q  <= isLastVec ? '0 : addr_q + ADDR_W'(1);
                state_q <= S_FETCH;
              end
            end else begin
              divCnt_q <= divCnt_q + DIV_W'(1);
            end
          end
        end

        S_DONE: begin
          tck_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          tck_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tck_o    = tck_q;
  assign tms_o    = tms_q;
  assign tdi_o    = tdi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign vec_idx  = vecIdx_q;
  assign tdo_word = tdoWord_q;

endmodule
